// File: rtl/arb_pkg.sv
// Shared types for the 4-requester round-robin arbiter.
// Requester order: A=0, B=1, C=2, D=3.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/onehot_enc_4to2.sv
// One-hot to 2-bit index encoder.
// Zero input encodes to 0.
module onehot_enc_4to2
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_oh,
  output req_idx_t         o_idx
);

  always_comb begin
    o_idx = '0;
    unique case (1'b1)
      i_oh[0]: o_idx = 2'd0;
      i_oh[1]: o_idx = 2'd1;
      i_oh[2]: o_idx = 2'd2;
      i_oh[3]: o_idx = 2'd3;
      default: o_idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_4to2.sv
// Round-robin 4-way arbiter with hold limit and registered grant.
// Priority rotates past the last owner on every release.
module rr_arbiter_4to2
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output req_idx_t         grant_idx,
  output logic             grant_valid
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_t       r_state;
  req_idx_t         r_ptr;
  logic [CW-1:0]    r_hold_cnt;
  logic [N_REQ-1:0] w_sel_oh;
  req_idx_t         w_sel_idx;
  req_idx_t         w_pos;
  logic             w_release;

  // Scan from the highest offset down so the nearest set bit wins.
  always_comb begin
    w_sel_oh = '0;
    w_pos    = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = r_ptr + req_idx_t'(k);
      if (req[w_pos]) begin
        w_sel_oh        = '0;
        w_sel_oh[w_pos] = 1'b1;
      end
    end
  end

  onehot_enc_4to2 u_enc (
    .i_oh  (w_sel_oh),
    .o_idx (w_sel_idx)
  );

  assign w_release = !req[grant_idx] || (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            grant       <= w_sel_oh;
            grant_idx   <= w_sel_idx;
            grant_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            r_ptr       <= grant_idx + 2'd1;
            r_hold_cnt  <= '0;
            r_state     <= IDLE;
          end else begin
            r_hold_cnt  <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
